// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM controller and its dead-time stage.
package pwm_pkg;

  localparam int PWM_W       = 8;
  localparam int DT_MIN_DEAD = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEAD_LH = 3'd1,
    ST_HI_ON   = 3'd2,
    ST_DEAD_HL = 3'd3,
    ST_LO_ON   = 3'd4,
    ST_FAULT   = 3'd5
  } dt_state_t;

  function automatic logic is_dead(input dt_state_t s);
    return (s == ST_DEAD_LH) || (s == ST_DEAD_HL);
  endfunction

endpackage

// File: rtl/dt_counter.sv
// Dead-interval down counter: load D (clamped to >= 1), expired pulses in the
// last cycle of the interval so the FSM leaves exactly D edges after the load.
module dt_counter
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] load_val,
  input  logic         load,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val < W'(DT_MIN_DEAD)) ? W'(DT_MIN_DEAD) : load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator: single-ended PWM in, hi/lo pair out with
// programmable both-off dead time, enable gating and a latched fault stop.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  input  logic [W-1:0] dead_cycles,
  input  logic         enable,
  input  logic         fault,
  output logic         hi_out,
  output logic         lo_out,
  output logic         dead_active,
  output logic         fault_latched
);

  dt_state_t state_q, state_d;
  logic      pwm_q, pwm_d;
  logic      hi_q, hi_d, lo_q, lo_d, dead_q, dead_d, flt_q, flt_d;
  logic      load, expired;

  dt_counter #(.W(W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_val (dead_cycles),
    .load     (load),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_in;
    if (fault) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      // Only leave fault with the PWM low so restart begins on the low side.
      if (!pwm_q) state_d = ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = pwm_q ? ST_DEAD_LH : ST_DEAD_HL;
        ST_LO_ON:   if (pwm_q)  state_d = ST_DEAD_LH;
        ST_HI_ON:   if (!pwm_q) state_d = ST_DEAD_HL;
        // A reversal inside a dead interval wins over expiry: restart, never skip.
        ST_DEAD_LH: if (!pwm_q) state_d = ST_DEAD_HL;
                    else if (expired) state_d = ST_HI_ON;
        ST_DEAD_HL: if (pwm_q) state_d = ST_DEAD_LH;
                    else if (expired) state_d = ST_LO_ON;
        default:    state_d = ST_IDLE;
      endcase
    end
    load   = is_dead(state_d) && (state_d != state_q);
    hi_d   = (state_d == ST_HI_ON);
    lo_d   = (state_d == ST_LO_ON);
    dead_d = is_dead(state_d);
    flt_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pwm_q   <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dead_q  <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dead_q  <= dead_d;
      flt_q   <= flt_d;
    end
  end

  assign hi_out        = hi_q;
  assign lo_out        = lo_q;
  assign dead_active   = dead_q;
  assign fault_latched = flt_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a cycle model queues expected outputs per
// edge, plus run-length monitors for pulse widths and dead gaps.
module tb_pwm_deadtime;

  localparam int W = 8;
  localparam int M_IDLE = 0, M_DEAD = 1, M_ON = 2, M_FLT = 3;

  logic         clk = 1'b0;
  logic         rst, pwm_in, enable, fault;
  logic [W-1:0] dead_cycles;
  logic         hi_out, lo_out, dead_active, fault_latched;

  always #5 clk = ~clk;

  pwm_deadtime #(.W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .dead_cycles   (dead_cycles),
    .enable        (enable),
    .fault         (fault),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .dead_active   (dead_active),
    .fault_latched (fault_latched)
  );

  typedef struct packed {logic hi; logic lo; logic dead; logic flt;} exp_t;
  exp_t q[$];

  int   m_mode = M_IDLE, m_e = 0, m_d = 1;
  logic m_tgt = 1'b0, m_pq = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   hi_cnt = 0, lo_cnt = 0, gap_cnt = 0, hi_total = 0;
  int   last_hi = 0, last_lo = 0, last_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference behaviour evaluated at each edge from the inputs then applied.
  task automatic model_step();
    exp_t e;
    logic p;
    if (!rst) begin
      m_mode = M_IDLE; m_pq = 1'b0; m_e = 0;
    end else begin
      p    = m_pq;
      m_pq = pwm_in;
      if (fault) m_mode = M_FLT;
      else if (m_mode == M_FLT) begin
        if (!p) m_mode = M_IDLE;
      end else if (!enable) m_mode = M_IDLE;
      else if (m_mode == M_IDLE || (m_mode != M_IDLE && p != m_tgt)) begin
        m_mode = M_DEAD; m_tgt = p; m_e = 1;
        m_d = (dead_cycles == 0) ? 1 : int'(dead_cycles);
      end else if (m_mode == M_DEAD) begin
        if (m_e == m_d) m_mode = M_ON;
        else m_e++;
      end
    end
    e.hi   = (m_mode == M_ON) && m_tgt;
    e.lo   = (m_mode == M_ON) && !m_tgt;
    e.dead = (m_mode == M_DEAD);
    e.flt  = (m_mode == M_FLT);
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("outs", {28'd0, hi_out, lo_out, dead_active, fault_latched},
          {28'd0, e.hi, e.lo, e.dead, e.flt});
    check("no_overlap", {31'd0, hi_out & lo_out}, 32'd0);
    if (hi_out) begin hi_cnt++; hi_total++; end
    else if (hi_cnt > 0) begin last_hi = hi_cnt; hi_cnt = 0; end
    if (lo_out) lo_cnt++;
    else if (lo_cnt > 0) begin last_lo = lo_cnt; lo_cnt = 0; end
    if (!hi_out && !lo_out) gap_cnt++;
    else if (gap_cnt > 0) begin last_gap = gap_cnt; gap_cnt = 0; end
  endtask

  task automatic run(input int n, input logic p);
    pwm_in = p;
    repeat (n) cyc();
  endtask

  task automatic pwm_periods(input int n, input int period, input int duty);
    for (int k = 0; k < n * period; k++) begin
      pwm_in = ((k % period) < duty);
      cyc();
    end
  endtask

  initial begin
    int n;
    int hi_before;
    rst = 1'b0; pwm_in = 1'b1; enable = 1'b1; fault = 1'b0; dead_cycles = 8'd3;
    repeat (3) cyc();
    check("rst_outs", {28'd0, hi_out, lo_out, dead_active, fault_latched}, 32'd0);

    // Release reset with pwm high: sync edge + 3 dead cycles, then hi.
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (hi_out) break;
      n++;
    end
    check("rst_lat", n, 4);

    dead_cycles = 8'd4;
    pwm_periods(4, 128, 32);
    check("pwm25_hi", last_hi, 28);
    check("pwm25_lo", last_lo, 92);
    check("pwm25_gap", last_gap, 4);

    dead_cycles = 8'd0;
    pwm_periods(2, 128, 32);
    check("d0_hi", last_hi, 31);
    check("d0_lo", last_lo, 95);
    check("d0_gap", last_gap, 1);

    // Two-cycle glitch while low side is on.
    dead_cycles = 8'd5;
    run(20, 1'b0);
    hi_before = hi_total;
    run(2, 1'b1);
    run(30, 1'b0);
    check("glitch_hi", hi_total - hi_before, 0);
    check("glitch_gap", last_gap, 7);
    check("glitch_lo", {31'd0, lo_out}, 32'd1);

    // Fault during HI_ON.
    dead_cycles = 8'd3;
    run(20, 1'b1);
    check("pre_fault_hi", {31'd0, hi_out}, 32'd1);
    fault = 1'b1;
    cyc();
    check("fault_hi", {31'd0, hi_out}, 32'd0);
    check("fault_latch", {31'd0, fault_latched}, 32'd1);
    fault = 1'b0;
    run(10, 1'b1);
    check("fault_hold", {31'd0, fault_latched}, 32'd1);
    pwm_in = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (lo_out) break;
      n++;
    end
    check("fault_recover", n, 5);

    // Dead-time change mid interval.
    dead_cycles = 8'd2;
    run(10, 1'b0);
    run(2, 1'b1);
    dead_cycles = 8'd6;
    run(20, 1'b1);
    check("dchg_first", last_gap, 2);
    run(20, 1'b0);
    check("dchg_next", last_gap, 6);

    // Enable drop and re-enable.
    enable = 1'b0;
    cyc();
    check("en_off", {30'd0, hi_out, lo_out}, 32'd0);
    run(5, 1'b0);
    enable = 1'b1;
    run(20, 1'b0);
    check("en_gap", last_gap, 6 + 6);

    // Reset in the middle of a dead interval.
    run(3, 1'b1);
    rst = 1'b0;
    cyc();
    check("rst_mid", {28'd0, hi_out, lo_out, dead_active, fault_latched}, 32'd0);
    rst = 1'b1;
    run(20, 1'b1);
    check("rst_mid_hi", {31'd0, hi_out}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
